// File: rtl/snake_render_pkg.sv
// Shared types, colour constants and default 640x480 timing for the snake map renderer.
package snake_render_pkg;

  typedef logic [9:0]        coord_t;
  typedef logic [23:0]       rgb_t;
  typedef logic [15:0][15:0] map_t;   // [row][column], column 0 is the leftmost cell

  localparam rgb_t COL_SNAKE    = 24'h00FF00;
  localparam rgb_t COL_DEAD     = 24'hFF0000;
  localparam rgb_t COL_EMPTY    = 24'h202020;
  localparam rgb_t COL_BORDER   = 24'hFFFFFF;
  localparam rgb_t COL_GRIDLINE = 24'h404040;
  localparam rgb_t COL_BG       = 24'h000000;

  localparam coord_t DEF_H_ACTIVE = 10'd640;
  localparam coord_t DEF_H_FP     = 10'd16;
  localparam coord_t DEF_H_SYNC   = 10'd96;
  localparam coord_t DEF_H_BP     = 10'd48;
  localparam coord_t DEF_V_ACTIVE = 10'd480;
  localparam coord_t DEF_V_FP     = 10'd10;
  localparam coord_t DEF_V_SYNC   = 10'd2;
  localparam coord_t DEF_V_BP     = 10'd33;
  localparam coord_t DEF_GRID_X0  = 10'd192;
  localparam coord_t DEF_GRID_Y0  = 10'd112;
  localparam int     DEF_CELL_SHIFT = 4;

endpackage

// File: rtl/snake_video_timing.sv
// Raster counters, raw (unpipelined) sync/DE and the map swap strobe at the start of
// the first vertical blanking line.
module snake_video_timing
  import snake_render_pkg::*;
#(
  parameter coord_t H_ACTIVE = DEF_H_ACTIVE,
  parameter coord_t H_FP     = DEF_H_FP,
  parameter coord_t H_SYNC   = DEF_H_SYNC,
  parameter coord_t H_BP     = DEF_H_BP,
  parameter coord_t V_ACTIVE = DEF_V_ACTIVE,
  parameter coord_t V_FP     = DEF_V_FP,
  parameter coord_t V_SYNC   = DEF_V_SYNC,
  parameter coord_t V_BP     = DEF_V_BP
) (
  input  logic   clk,
  input  logic   rst,
  output coord_t hcnt,
  output coord_t vcnt,
  output logic   hs,
  output logic   vs,
  output logic   de,
  output logic   swap
);

  localparam coord_t H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam coord_t V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_TOTAL - 10'd1) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_TOTAL - 10'd1) ? '0 : vcnt + 10'd1;
    end else begin
      hcnt <= hcnt + 10'd1;
    end
  end

  assign hs   = !(hcnt >= H_ACTIVE + H_FP && hcnt < H_ACTIVE + H_FP + H_SYNC);
  assign vs   = !(vcnt >= V_ACTIVE + V_FP && vcnt < V_ACTIVE + V_FP + V_SYNC);
  assign de   = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE);
  assign swap = (hcnt == '0) && (vcnt == V_ACTIVE);

endmodule

// File: rtl/snake_map_render.sv
// Double-buffered 16x16 snake map rendered into a 2-stage RGB888 video pipeline.
// Optional build macro SNAKE_MAP_GRIDLINE_EN draws grid lines on empty cells.
module snake_map_render
  import snake_render_pkg::*;
#(
  parameter coord_t H_ACTIVE   = DEF_H_ACTIVE,
  parameter coord_t H_FP       = DEF_H_FP,
  parameter coord_t H_SYNC     = DEF_H_SYNC,
  parameter coord_t H_BP       = DEF_H_BP,
  parameter coord_t V_ACTIVE   = DEF_V_ACTIVE,
  parameter coord_t V_FP       = DEF_V_FP,
  parameter coord_t V_SYNC     = DEF_V_SYNC,
  parameter coord_t V_BP       = DEF_V_BP,
  parameter coord_t GRID_X0    = DEF_GRID_X0,
  parameter coord_t GRID_Y0    = DEF_GRID_Y0,
  parameter int     CELL_SHIFT = DEF_CELL_SHIFT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] snake_map_arr_0,
  input  logic [15:0] snake_map_arr_1,
  input  logic [15:0] snake_map_arr_2,
  input  logic [15:0] snake_map_arr_3,
  input  logic [15:0] snake_map_arr_4,
  input  logic [15:0] snake_map_arr_5,
  input  logic [15:0] snake_map_arr_6,
  input  logic [15:0] snake_map_arr_7,
  input  logic [15:0] snake_map_arr_8,
  input  logic [15:0] snake_map_arr_9,
  input  logic [15:0] snake_map_arr_10,
  input  logic [15:0] snake_map_arr_11,
  input  logic [15:0] snake_map_arr_12,
  input  logic [15:0] snake_map_arr_13,
  input  logic [15:0] snake_map_arr_14,
  input  logic [15:0] snake_map_arr_15,
  input  logic        hdmi_tx_en,
  input  logic        game_over_flag,
  output logic        vid_hs,
  output logic        vid_vs,
  output logic        vid_de,
  output logic [7:0]  vid_r,
  output logic [7:0]  vid_g,
  output logic [7:0]  vid_b,
  output logic        frame_start,
  output logic        map_pending
);

  localparam coord_t GRID_W = coord_t'(16 << CELL_SHIFT);

  coord_t hcnt, vcnt;
  logic   raw_hs, raw_vs, raw_de, swap;

  snake_video_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk(clk), .rst(rst), .hcnt(hcnt), .vcnt(vcnt),
    .hs(raw_hs), .vs(raw_vs), .de(raw_de), .swap(swap)
  );

  map_t live_map, shadow_map, active_map;
  logic shadow_go, active_go;

  assign live_map = {snake_map_arr_15, snake_map_arr_14, snake_map_arr_13, snake_map_arr_12,
                     snake_map_arr_11, snake_map_arr_10, snake_map_arr_9,  snake_map_arr_8,
                     snake_map_arr_7,  snake_map_arr_6,  snake_map_arr_5,  snake_map_arr_4,
                     snake_map_arr_3,  snake_map_arr_2,  snake_map_arr_1,  snake_map_arr_0};

  // NOTE: both map buffers are plain flops, not RAM, so they can and do take the async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_map  <= '0;
      shadow_go   <= 1'b0;
      active_map  <= '0;
      active_go   <= 1'b0;
      map_pending <= 1'b0;
    end else if (swap && hdmi_tx_en) begin
      // A map arriving exactly at the swap point bypasses the shadow stage.
      shadow_map  <= live_map;
      shadow_go   <= game_over_flag;
      active_map  <= live_map;
      active_go   <= game_over_flag;
      map_pending <= 1'b0;
    end else if (swap && map_pending) begin
      active_map  <= shadow_map;
      active_go   <= shadow_go;
      map_pending <= 1'b0;
    end else if (hdmi_tx_en) begin
      shadow_map  <= live_map;
      shadow_go   <= game_over_flag;
      map_pending <= 1'b1;
    end
  end

  // Stage 1: grid geometry and row fetch.
  coord_t dx, dy;
  logic   in_grid, on_ring;

  assign dx      = hcnt - GRID_X0;
  assign dy      = vcnt - GRID_Y0;
  assign in_grid = (hcnt >= GRID_X0) && (hcnt < GRID_X0 + GRID_W) &&
                   (vcnt >= GRID_Y0) && (vcnt < GRID_Y0 + GRID_W);
  assign on_ring = (hcnt >= GRID_X0 - 10'd1) && (hcnt <= GRID_X0 + GRID_W) &&
                   (vcnt >= GRID_Y0 - 10'd1) && (vcnt <= GRID_Y0 + GRID_W);

  logic        hs1, vs1, de1, fs1, in_grid1, border1;
  logic [15:0] row1;
  logic [3:0]  cx1;
`ifdef SNAKE_MAP_GRIDLINE_EN
  logic        gl1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs1      <= 1'b1;
      vs1      <= 1'b1;
      de1      <= 1'b0;
      fs1      <= 1'b0;
      in_grid1 <= 1'b0;
      border1  <= 1'b0;
      row1     <= '0;
      cx1      <= '0;
`ifdef SNAKE_MAP_GRIDLINE_EN
      gl1      <= 1'b0;
`endif
    end else begin
      hs1      <= raw_hs;
      vs1      <= raw_vs;
      de1      <= raw_de;
      fs1      <= raw_de && (hcnt == '0) && (vcnt == '0);
      in_grid1 <= in_grid;
      border1  <= on_ring && !in_grid;
      row1     <= active_map[4'(dy >> CELL_SHIFT)];
      cx1      <= 4'(dx >> CELL_SHIFT);
`ifdef SNAKE_MAP_GRIDLINE_EN
      gl1      <= (dx[CELL_SHIFT-1:0] == '0) || (dy[CELL_SHIFT-1:0] == '0);
`endif
    end
  end

  // Stage 2: colour selection.
  rgb_t pix_rgb;

  // NOTE: pix_rgb is defaulted first so no branch can leave it unassigned and infer a latch.
  always_comb begin
    pix_rgb = COL_BG;
    if (de1) begin
      if (in_grid1) begin
        if (row1[cx1])
          pix_rgb = active_go ? COL_DEAD : COL_SNAKE;
`ifdef SNAKE_MAP_GRIDLINE_EN
        else if (gl1)
          pix_rgb = COL_GRIDLINE;
`endif
        else
          pix_rgb = COL_EMPTY;
      end else if (border1) begin
        pix_rgb = COL_BORDER;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vid_hs      <= 1'b1;
      vid_vs      <= 1'b1;
      vid_de      <= 1'b0;
      frame_start <= 1'b0;
      {vid_r, vid_g, vid_b} <= COL_BG;
    end else begin
      vid_hs      <= hs1;
      vid_vs      <= vs1;
      vid_de      <= de1;
      frame_start <= fs1;
      {vid_r, vid_g, vid_b} <= pix_rgb;
    end
  end

endmodule

// File: tb/tb_snake_map_render.sv
// Randomized bench for snake_map_render on a shrunken raster, checked pixel by pixel
// against a frame-level reference model. Honors SNAKE_MAP_GRIDLINE_EN like the design.
module tb_snake_map_render;

  localparam int HA = 40, HF = 2, HS = 4, HB = 2;
  localparam int VA = 40, VF = 1, VS = 2, VB = 2;
  localparam int GX0 = 4, GY0 = 3, CS = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int CELL = 1 << CS;
  localparam int GW = 16 * CELL;
  localparam int N_FRAMES = 14;
  localparam logic [27:0] OUT_RST = {1'b1, 1'b1, 1'b0, 1'b0, 24'h000000};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] arr [16];
  logic        tx_en = 1'b0;
  logic        go_in = 1'b0;
  logic        vid_hs, vid_vs, vid_de, frame_start, map_pending;
  logic [7:0]  vid_r, vid_g, vid_b;

  always #5 clk = ~clk;

  snake_map_render #(
    .H_ACTIVE(10'(HA)), .H_FP(10'(HF)), .H_SYNC(10'(HS)), .H_BP(10'(HB)),
    .V_ACTIVE(10'(VA)), .V_FP(10'(VF)), .V_SYNC(10'(VS)), .V_BP(10'(VB)),
    .GRID_X0(10'(GX0)), .GRID_Y0(10'(GY0)), .CELL_SHIFT(CS)
  ) dut (
    .clk(clk), .rst(rst),
    .snake_map_arr_0(arr[0]),   .snake_map_arr_1(arr[1]),   .snake_map_arr_2(arr[2]),
    .snake_map_arr_3(arr[3]),   .snake_map_arr_4(arr[4]),   .snake_map_arr_5(arr[5]),
    .snake_map_arr_6(arr[6]),   .snake_map_arr_7(arr[7]),   .snake_map_arr_8(arr[8]),
    .snake_map_arr_9(arr[9]),   .snake_map_arr_10(arr[10]), .snake_map_arr_11(arr[11]),
    .snake_map_arr_12(arr[12]), .snake_map_arr_13(arr[13]), .snake_map_arr_14(arr[14]),
    .snake_map_arr_15(arr[15]),
    .hdmi_tx_en(tx_en), .game_over_flag(go_in),
    .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de),
    .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b),
    .frame_start(frame_start), .map_pending(map_pending)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cycle    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cycle, got, exp);
  endtask

  // Reference model: what the screen should show, expressed with the display rules directly.
  logic [15:0] m_shadow [16];
  logic [15:0] m_active [16];
  bit          m_shadow_go, m_active_go, m_pending;
  int          h, v, frame;
  logic [27:0] exp_q [2];   // [0] = pixel entering the pipe, [1] = pixel now on the pins

  function automatic logic [23:0] colour(input int x, input int y);
    if (x >= GX0 && x < GX0 + GW && y >= GY0 && y < GY0 + GW) begin
      int c = (x - GX0) / CELL;
      int r = (y - GY0) / CELL;
      if (m_active[r][c]) return m_active_go ? 24'hFF0000 : 24'h00FF00;
`ifdef SNAKE_MAP_GRIDLINE_EN
      if ((x - GX0) % CELL == 0 || (y - GY0) % CELL == 0) return 24'h404040;
`endif
      return 24'h202020;
    end
    if (x >= GX0 - 1 && x <= GX0 + GW && y >= GY0 - 1 && y <= GY0 + GW) return 24'hFFFFFF;
    return 24'h000000;
  endfunction

  function automatic logic [27:0] expect_out(input int x, input int y);
    bit de = (x < HA) && (y < VA);
    bit hs = !(x >= HA + HF && x < HA + HF + HS);
    bit vs = !(y >= VA + VF && y < VA + VF + VS);
    bit fs = de && (x == 0) && (y == 0);
    return {hs, vs, de, fs, (de ? colour(x, y) : 24'h000000)};
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 16; r++) begin
      m_shadow[r] = '0;
      m_active[r] = '0;
    end
    m_shadow_go = 0;
    m_active_go = 0;
    m_pending   = 0;
    h = 0;
    v = 0;
    exp_q[0] = OUT_RST;
    exp_q[1] = OUT_RST;
  endtask

  task automatic random_map();
    for (int r = 0; r < 16; r++) arr[r] = 16'($urandom);
    go_in = 1'($urandom);
    tx_en = 1'b1;
  endtask

  task automatic check_outputs(input string tag);
    check(tag, {4'h0, vid_hs, vid_vs, vid_de, frame_start, vid_r, vid_g, vid_b}, {4'h0, exp_q[1]});
    check("map_pending", {31'd0, map_pending}, {31'd0, m_pending});
  endtask

  // Apply the rules to the coming clock edge, then move to the next falling edge.
  task automatic step();
    logic [27:0] px = expect_out(h, v);
    bit at_swap = (h == 0) && (v == VA);
    if (at_swap && tx_en) begin
      for (int r = 0; r < 16; r++) begin
        m_active[r] = arr[r];
        m_shadow[r] = arr[r];
      end
      m_active_go = go_in;
      m_shadow_go = go_in;
      m_pending   = 0;
    end else if (at_swap && m_pending) begin
      for (int r = 0; r < 16; r++) m_active[r] = m_shadow[r];
      m_active_go = m_shadow_go;
      m_pending   = 0;
    end else if (tx_en) begin
      for (int r = 0; r < 16; r++) m_shadow[r] = arr[r];
      m_shadow_go = go_in;
      m_pending   = 1;
    end
    exp_q[1] = exp_q[0];
    exp_q[0] = px;
    h++;
    if (h == HT) begin
      h = 0;
      v++;
      if (v == VT) begin
        v = 0;
        frame++;
      end
    end
    @(negedge clk);
    cycle++;
  endtask

  initial begin
    bit did_reset = 0;
    for (int r = 0; r < 16; r++) arr[r] = '0;
    model_reset();
    frame = 0;
    repeat (3) @(negedge clk);
    check_outputs("reset_pins");
    rst = 1'b0;

    while (frame < N_FRAMES) begin
      tx_en = 1'b0;
      if (frame == 0 && v == 5 && h == 5) begin
        for (int r = 0; r < 16; r++) arr[r] = '0;
        arr[3] = 16'h0001;
        go_in  = 1'b0;
        tx_en  = 1'b1;
      end else if (frame == 1 && v == 20 && h == 10) begin
        random_map();
        go_in = 1'b0;
      end else if (frame == 2 && v == VA && h == 0) begin
        random_map();
        go_in = 1'b1;
      end else if (frame == 3 && v == 10 && (h == 3 || h == 4)) begin
        random_map();
      end else if (frame == 4 && v == 5 && h == 0 && !did_reset) begin
        random_map();
      end else if (frame == 4 && v == 10 && h == 7 && !did_reset) begin
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("midframe_reset_pins");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        did_reset = 1;
        continue;
      end else if (frame == 6 && (v == 30 || v == VA) && h == 0) begin
        random_map();
      end else if (frame >= 7 && $urandom_range(0, 399) == 0) begin
        random_map();
      end
      step();
      check_outputs("pins");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
